// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX.
// Produces one quotient bit per cycle and holds the result until EX hands off.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_x,
    input  logic [WIDTH-1:0] div_y,
    input  logic             div_ack,
    input  logic             flush,
    output logic             div_stop,
    output logic             div_done,
    output logic [WIDTH-1:0] div_quot,
    output logic [WIDTH-1:0] div_rem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifts out MSB-first while quotient shifts in
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic               sign_quot_q, sign_quot_d;
    logic               sign_rem_q, sign_rem_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;

    logic               x_neg, y_neg;
    logic [WIDTH:0]     part_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   part_step;
    logic [WIDTH-1:0]   quot_step;

    assign x_neg     = div_signed & div_x[WIDTH-1];
    assign y_neg     = div_signed & div_y[WIDTH-1];
    assign part_sh   = {part_q, dvd_q[WIDTH-1]};
    assign diff      = part_sh - {1'b0, dvs_q};
    assign q_bit     = ~diff[WIDTH];
    assign part_step = q_bit ? diff[WIDTH-1:0] : part_sh[WIDTH-1:0];
    assign quot_step = {dvd_q[WIDTH-2:0], q_bit};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        part_d      = part_q;
        sign_quot_d = sign_quot_q;
        sign_rem_d  = sign_rem_q;
        done_d      = done_q;
        quot_d      = quot_q;
        rem_d       = rem_q;

        case (state_q)
            IDLE: begin
                if (div_req) begin
                    dvd_d       = x_neg ? -div_x : div_x;
                    dvs_d       = y_neg ? -div_y : div_y;
                    sign_quot_d = x_neg ^ y_neg;
                    sign_rem_d  = x_neg;
                    part_d      = '0;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                dvd_d  = quot_step;
                part_d = part_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quot_d  = sign_quot_q ? -quot_step : quot_step;
                    rem_d   = sign_rem_q ? -part_step : part_step;
                end
            end
            DONE: begin
                if (div_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush kills any operation, including one requested this cycle.
        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            sign_quot_q <= 1'b0;
            sign_rem_q  <= 1'b0;
            done_q      <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            part_q      <= part_d;
            sign_quot_q <= sign_quot_d;
            sign_rem_q  <= sign_rem_d;
            done_q      <= done_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
        end
    end

    assign div_stop = div_req & ~done_q;
    assign div_done = done_q;
    assign div_quot = quot_q;
    assign div_rem  = rem_q;

    // The requesting instruction must stay in EX while the divide runs.
    always @(posedge clk) begin
        if (!reset && state_q == BUSY && !flush) begin
            assert (div_req);
        end
    end

endmodule
